// File: rtl/tmr_voter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_voter_seq
//  Purpose  : Registered, valid/ready handshaked N-modular-redundancy voter
//             for replicated ALU results (3 or 5 lanes). Each accepted beat
//             is voted over the currently healthy lanes. Every lane keeps a
//             disagreement history: a lane that sits in the minority for
//             FAULT_THRESH consecutive majority beats is retired (FAILED).
//             Voting then continues over the remaining healthy lanes, in
//             degraded mode when fewer than three lanes remain.
//
//  Ports    : clk               - clock, rising edge
//             rst_n             - asynchronous active-low reset
//             in_valid/in_ready - input handshake (in_ready is combinational)
//             in_data           - lane i at [i*WIDTH +: WIDTH]
//             out_valid/out_ready - output handshake, 1-cycle latency
//             out_data          - voted word
//             out_no_majority   - no majority existed for this beat
//             out_minority_mask - healthy lanes that disagreed with out_data
//             out_degraded      - fewer than 3 healthy lanes at vote time
//             clr_fault         - per-lane pulse: back to HEALTHY, counter 0
//             ch_failed         - per-lane FAILED flag
//             ch_err_cnt        - per-lane saturating minority-vote count
//
//  Build    : define TMR_VOTER_BITWISE_EN to replace the word vote with a
//             per-bit majority vote (ties resolved by lowest healthy lane).
//
//  Revision : 1.0 - initial release
// ============================================================================
module tmr_voter_seq #(
    parameter int WIDTH        = 64,
    parameter int NUM_CH       = 3,
    parameter int FAULT_THRESH = 4,
    parameter int CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_no_majority,
    output logic [NUM_CH-1:0]       out_minority_mask,
    output logic                    out_degraded,
    input  logic [NUM_CH-1:0]       clr_fault,
    output logic [NUM_CH-1:0]       ch_failed,
    output logic [NUM_CH*CNT_W-1:0] ch_err_cnt
);

    // Lane counts never exceed 5, so 3 bits hold any healthy-set size.
    localparam int                  CH_CNT_W   = 3;
    localparam logic [CH_CNT_W-1:0] CH_ONE     = CH_CNT_W'(1);
    localparam logic [CH_CNT_W-1:0] MIN_FULL_H = CH_CNT_W'(3);
    localparam logic [3:0]          THRESH     = 4'(FAULT_THRESH);
    localparam logic [CNT_W-1:0]    ERR_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        CH_HEALTHY = 2'd0,
        CH_SUSPECT = 2'd1,
        CH_FAILED  = 2'd2
    } ch_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ch_state_e          st_q     [NUM_CH];
    ch_state_e          st_d     [NUM_CH];
    logic [3:0]         consec_q [NUM_CH];
    logic [3:0]         consec_d [NUM_CH];
    logic [CNT_W-1:0]   err_q    [NUM_CH];
    logic [CNT_W-1:0]   err_d    [NUM_CH];

    logic               out_valid_q,   out_valid_d;
    logic [WIDTH-1:0]   out_data_q,    out_data_d;
    logic               out_nomaj_q,   out_nomaj_d;
    logic [NUM_CH-1:0]  out_mask_q,    out_mask_d;
    logic               out_degr_q,    out_degr_d;

    // ------------------------------------------------------------------
    // Combinational vote
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    w_word [NUM_CH];
    logic [NUM_CH-1:0]   w_healthy;
    logic [CH_CNT_W-1:0] w_h;
    logic [CH_CNT_W-1:0] w_half;
    logic [WIDTH-1:0]    w_first_word;
    logic                w_first_found;
    logic [WIDTH-1:0]    w_vote_data;
    logic                w_majority;
    logic [NUM_CH-1:0]   w_minority;
    logic                w_accept;

    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        assign w_word[gi]     = in_data[gi*WIDTH +: WIDTH];
        assign w_healthy[gi]  = (st_q[gi] != CH_FAILED);
        assign ch_failed[gi]  = (st_q[gi] == CH_FAILED);
        assign ch_err_cnt[gi*CNT_W +: CNT_W] = err_q[gi];
        // Only meaningful when a majority exists; otherwise no lane is blamed.
        assign w_minority[gi] = w_majority && w_healthy[gi] &&
                                (w_word[gi] != w_vote_data);
    end

    // Healthy-set size and the lowest-index healthy word (fallback result).
    always_comb begin
        w_h           = '0;
        w_first_found = 1'b0;
        w_first_word  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_healthy[i]) begin
                w_h = w_h + CH_ONE;
                if (!w_first_found) begin
                    w_first_found = 1'b1;
                    w_first_word  = w_word[i];
                end
            end
        end
    end

    assign w_half = w_h >> 1;

`ifdef TMR_VOTER_BITWISE_EN
    logic [CH_CNT_W-1:0] w_ones;
    logic [CH_CNT_W-1:0] w_zeros;
    logic                w_tie;

    // Per-bit majority; a bit with no strict majority (even h) is a tie and
    // takes its value from the lowest-index healthy lane.
    always_comb begin
        w_vote_data = '0;
        w_tie       = 1'b0;
        w_ones      = '0;
        w_zeros     = '0;
        for (int b = 0; b < WIDTH; b++) begin
            w_ones = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_healthy[i] && w_word[i][b]) begin
                    w_ones = w_ones + CH_ONE;
                end
            end
            w_zeros = w_h - w_ones;
            if (w_ones > w_half) begin
                w_vote_data[b] = 1'b1;
            end else if (w_zeros > w_half) begin
                w_vote_data[b] = 1'b0;
            end else begin
                w_vote_data[b] = w_first_word[b];
                w_tie          = 1'b1;
            end
        end
        w_majority = (w_h != '0) && !w_tie;
    end
`else
    logic [CH_CNT_W-1:0] w_agree;

    // Word vote: the lowest-index healthy lane agreed with by more than
    // half of the healthy set wins. Without a winner the lowest healthy
    // lane (or zero when none is left) is passed through.
    always_comb begin
        w_vote_data = w_first_word;
        w_majority  = 1'b0;
        w_agree     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_agree = '0;
            for (int j = 0; j < NUM_CH; j++) begin
                if (w_healthy[j] && (w_word[j] == w_word[i])) begin
                    w_agree = w_agree + CH_ONE;
                end
            end
            if (w_healthy[i] && !w_majority && (w_agree > w_half)) begin
                w_majority  = 1'b1;
                w_vote_data = w_word[i];
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Per-lane health tracking
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            st_d[i]     = st_q[i];
            consec_d[i] = consec_q[i];
            err_d[i]    = err_q[i];
            if (clr_fault[i]) begin
                // Clear wins over any vote update in the same cycle.
                st_d[i]     = CH_HEALTHY;
                consec_d[i] = '0;
                err_d[i]    = '0;
            end else if (w_accept && w_majority && w_healthy[i]) begin
                if (w_minority[i]) begin
                    if (err_q[i] != '1) begin
                        err_d[i] = err_q[i] + ERR_ONE;
                    end
                    if (st_q[i] == CH_HEALTHY) begin
                        consec_d[i] = 4'd1;
                    end else begin
                        consec_d[i] = consec_q[i] + 4'd1;
                    end
                    st_d[i] = (consec_d[i] >= THRESH) ? CH_FAILED : CH_SUSPECT;
                end else begin
                    st_d[i]     = CH_HEALTHY;
                    consec_d[i] = '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: loads on accept, holds while stalled
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_nomaj_d = out_nomaj_q;
        out_mask_d  = out_mask_q;
        out_degr_d  = out_degr_q;
        if (w_accept) begin
            out_valid_d = 1'b1;
            out_data_d  = w_vote_data;
            out_nomaj_d = !w_majority;
            out_mask_d  = w_minority;
            out_degr_d  = (w_h < MIN_FULL_H);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_nomaj_q <= 1'b0;
            out_mask_q  <= '0;
            out_degr_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]     <= CH_HEALTHY;
                consec_q[i] <= '0;
                err_q[i]    <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_nomaj_q <= out_nomaj_d;
            out_mask_q  <= out_mask_d;
            out_degr_q  <= out_degr_d;
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]     <= st_d[i];
                consec_q[i] <= consec_d[i];
                err_q[i]    <= err_d[i];
            end
        end
    end

    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_no_majority   = out_nomaj_q;
    assign out_minority_mask = out_mask_q;
    assign out_degraded      = out_degr_q;

endmodule
`default_nettype wire

// File: tb/tb_tmr_voter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmr_voter_seq
//  Purpose  : Self-checking bench for tmr_voter_seq. Drives a 3-lane and a
//             5-lane instance (the 5-lane one with a 3-bit error counter so
//             saturation is reachable) and compares against a lane-level
//             reference model of the vote and the retirement rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_voter_seq;

    localparam int W = 16;

    logic clk;
    logic rst_n;

    // 3-lane instance
    logic          in_valid3, in_ready3, out_valid3, out_ready3;
    logic [3*W-1:0] in_data3;
    logic [W-1:0]  out_data3;
    logic          nomaj3, degr3;
    logic [2:0]    mask3, clr3, failed3;
    logic [23:0]   errcnt3;

    // 5-lane instance
    logic          in_valid5, in_ready5, out_valid5, out_ready5;
    logic [5*W-1:0] in_data5;
    logic [W-1:0]  out_data5;
    logic          nomaj5, degr5;
    logic [4:0]    mask5, clr5, failed5;
    logic [14:0]   errcnt5;

    tmr_voter_seq #(.WIDTH(W), .NUM_CH(3), .FAULT_THRESH(4), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .out_no_majority(nomaj3), .out_minority_mask(mask3), .out_degraded(degr3),
        .clr_fault(clr3), .ch_failed(failed3), .ch_err_cnt(errcnt3)
    );

    tmr_voter_seq #(.WIDTH(W), .NUM_CH(5), .FAULT_THRESH(4), .CNT_W(3)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
        .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
        .out_no_majority(nomaj5), .out_minority_mask(mask5), .out_degraded(degr5),
        .clr_fault(clr5), .ch_failed(failed5), .ch_err_cnt(errcnt5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Reference model (index 0 = 3-lane instance, 1 = 5-lane instance)
    // ------------------------------------------------------------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [W-1:0] lane [5];
    int          m_cons [2][5];
    int          m_err  [2][5];
    bit          m_fail [2][5];
    logic [W-1:0] e_data [2];
    bit          e_nomaj [2];
    bit          e_degr  [2];
    logic [4:0]  e_mask  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) begin
                m_cons[k][i] = 0;
                m_err[k][i]  = 0;
                m_fail[k][i] = 0;
            end
            e_data[k] = '0; e_nomaj[k] = 0; e_degr[k] = 0; e_mask[k] = '0;
        end
    endtask

    task automatic model_beat(input int k, input bit acc, input logic [4:0] clr);
        int n, h, half, agree, ones, emax;
        bit maj, found;
        bit hl [5];
        logic [W-1:0] v, first;
        n    = (k == 0) ? 3 : 5;
        emax = (k == 0) ? 255 : 7;
        h = 0; found = 0; first = '0; maj = 0;
        for (int i = 0; i < 5; i++) begin
            hl[i] = (i < n) && !m_fail[k][i];
            if (hl[i]) begin
                h++;
                if (!found) begin found = 1; first = lane[i]; end
            end
        end
        half = h / 2;
        v    = first;
        if (acc) begin
`ifdef TMR_VOTER_BITWISE_EN
            maj = (h > 0);
            for (int b = 0; b < W; b++) begin
                ones = 0;
                for (int i = 0; i < n; i++) if (hl[i] && lane[i][b]) ones++;
                if (ones > half)          v[b] = 1'b1;
                else if (h - ones > half) v[b] = 1'b0;
                else begin v[b] = first[b]; maj = 0; end
            end
`else
            for (int i = 0; i < n; i++) begin
                if (hl[i] && !maj) begin
                    agree = 0;
                    for (int j = 0; j < n; j++) if (hl[j] && lane[j] == lane[i]) agree++;
                    if (agree > half) begin maj = 1; v = lane[i]; end
                end
            end
`endif
            e_data[k]  = v;
            e_nomaj[k] = !maj;
            e_degr[k]  = (h < 3);
            e_mask[k]  = '0;
            for (int i = 0; i < n; i++) if (maj && hl[i] && lane[i] != v) e_mask[k][i] = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            if (clr[i]) begin
                m_fail[k][i] = 0; m_cons[k][i] = 0; m_err[k][i] = 0;
            end else if (acc && maj && hl[i]) begin
                if (e_mask[k][i]) begin
                    if (m_err[k][i] < emax) m_err[k][i]++;
                    m_cons[k][i]++;
                    if (m_cons[k][i] >= 4) m_fail[k][i] = 1;
                end else begin
                    m_cons[k][i] = 0;
                end
            end
        end
    endtask

    task automatic check_out(input int k, input string tag);
        logic [4:0] fexp;
        fexp = '0;
        for (int i = 0; i < 5; i++) fexp[i] = m_fail[k][i];
        if (k == 0) begin
            chk({tag, "/out_valid"},     64'(out_valid3), 64'd1);
            chk({tag, "/out_data"},      64'(out_data3),  64'(e_data[0]));
            chk({tag, "/no_majority"},   64'(nomaj3),     64'(e_nomaj[0]));
            chk({tag, "/minority_mask"}, 64'(mask3),      64'(e_mask[0][2:0]));
            chk({tag, "/degraded"},      64'(degr3),      64'(e_degr[0]));
            chk({tag, "/ch_failed"},     64'(failed3),    64'(fexp[2:0]));
            for (int i = 0; i < 3; i++)
                chk($sformatf("%s/err_cnt%0d", tag, i), 64'(errcnt3[i*8 +: 8]), 64'(m_err[0][i]));
        end else begin
            chk({tag, "/out_valid"},     64'(out_valid5), 64'd1);
            chk({tag, "/out_data"},      64'(out_data5),  64'(e_data[1]));
            chk({tag, "/no_majority"},   64'(nomaj5),     64'(e_nomaj[1]));
            chk({tag, "/minority_mask"}, 64'(mask5),      64'(e_mask[1]));
            chk({tag, "/degraded"},      64'(degr5),      64'(e_degr[1]));
            chk({tag, "/ch_failed"},     64'(failed5),    64'(fexp));
            for (int i = 0; i < 5; i++)
                chk($sformatf("%s/err_cnt%0d", tag, i), 64'(errcnt5[i*3 +: 3]), 64'(m_err[1][i]));
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "/valid3"},  64'(out_valid3), 64'd0);
        chk({tag, "/data3"},   64'(out_data3),  64'd0);
        chk({tag, "/nomaj3"},  64'(nomaj3),     64'd0);
        chk({tag, "/mask3"},   64'(mask3),      64'd0);
        chk({tag, "/degr3"},   64'(degr3),      64'd0);
        chk({tag, "/failed3"}, 64'(failed3),    64'd0);
        chk({tag, "/errcnt3"}, 64'(errcnt3),    64'd0);
        chk({tag, "/valid5"},  64'(out_valid5), 64'd0);
        chk({tag, "/data5"},   64'(out_data5),  64'd0);
        chk({tag, "/failed5"}, 64'(failed5),    64'd0);
        chk({tag, "/errcnt5"}, 64'(errcnt5),    64'd0);
    endtask

    // One accepted beat on instance k with out_ready high; ends 1 time unit
    // after the capturing edge with the result checked.
    task automatic beat(input int k, input logic [4:0] clr);
        if (k == 0) begin
            in_data3 = {lane[2], lane[1], lane[0]};
            clr3 = clr[2:0]; in_valid3 = 1'b1; out_ready3 = 1'b1;
            #1 chk("beat3/in_ready", 64'(in_ready3), 64'd1);
        end else begin
            in_data5 = {lane[4], lane[3], lane[2], lane[1], lane[0]};
            clr5 = clr; in_valid5 = 1'b1; out_ready5 = 1'b1;
            #1 chk("beat5/in_ready", 64'(in_ready5), 64'd1);
        end
        model_beat(k, 1'b1, clr);
        @(posedge clk); #1;
        in_valid3 = 1'b0; in_valid5 = 1'b0; clr3 = '0; clr5 = '0;
        if (k == 0) check_out(0, "beat3");
        else        check_out(1, "beat5");
    endtask

    task automatic idle();
        in_valid3 = 1'b0; in_valid5 = 1'b0; out_ready3 = 1'b1; out_ready5 = 1'b1;
        clr3 = '0; clr5 = '0;
        @(posedge clk); #1;
        chk("idle/valid3", 64'(out_valid3), 64'd0);
        chk("idle/valid5", 64'(out_valid5), 64'd0);
    endtask

    task automatic set_lanes(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                             input logic [W-1:0] d, input logic [W-1:0] e);
        lane[0] = a; lane[1] = b; lane[2] = c; lane[3] = d; lane[4] = e;
    endtask

    // ------------------------------------------------------------------
    // Directed steps followed by randomized traffic
    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0] base, alt;
        logic [4:0]   clr;
        int           k, r;

        in_valid3 = 0; out_ready3 = 1; in_data3 = '0; clr3 = '0;
        in_valid5 = 0; out_ready5 = 1; in_data5 = '0; clr5 = '0;
        set_lanes('0, '0, '0, '0, '0);
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        chk("reset/in_ready3", 64'(in_ready3), 64'd1);
        rst_n = 1'b1;

        // All lanes agree
        set_lanes(16'h1234, 16'h1234, 16'h1234, 0, 0);
        beat(0, 5'b0);
        chk("agree/data", 64'(out_data3), 64'h1234);
        chk("agree/mask", 64'(mask3), 64'd0);

        // Lane 2 persistently wrong: retired after the fourth beat
        set_lanes(16'h0005, 16'h0005, 16'hDEAD, 0, 0);
        for (int b = 0; b < 4; b++) begin
            beat(0, 5'b0);
            chk("lane2_bad/data", 64'(out_data3), 64'h5);
            chk("lane2_bad/mask", 64'(mask3), 64'b100);
        end
        chk("lane2_bad/failed", 64'(failed3), 64'b100);
        chk("lane2_bad/err2", 64'(errcnt3[23:16]), 64'd4);
        beat(0, 5'b0);
        chk("degraded/flag", 64'(degr3), 64'd1);

        // Clear takes priority over a same-cycle minority beat on lane 2
        beat(0, 5'b00100);
        chk("clr/failed", 64'(failed3), 64'd0);
        chk("clr/err2", 64'(errcnt3[23:16]), 64'd0);

        // Three-way disagreement
        set_lanes(16'h1, 16'h2, 16'h3, 0, 0);
        beat(0, 5'b0);
`ifndef TMR_VOTER_BITWISE_EN
        chk("nomaj/flag", 64'(nomaj3), 64'd1);
        chk("nomaj/data", 64'(out_data3), 64'h1);
`endif

        // Back-pressure: output held, nothing lost
        idle();
        set_lanes(16'h0011, 16'h0011, 16'h0011, 0, 0);
        in_data3 = {lane[2], lane[1], lane[0]};
        in_valid3 = 1'b1; out_ready3 = 1'b0;
        #1 chk("stall/in_ready_first", 64'(in_ready3), 64'd1);
        model_beat(0, 1'b1, 5'b0);
        @(posedge clk); #1;
        check_out(0, "stall_a");
        set_lanes(16'h0022, 16'h0022, 16'h0022, 0, 0);
        in_data3 = {lane[2], lane[1], lane[0]};
        for (int c = 0; c < 3; c++) begin
            chk("stall/in_ready", 64'(in_ready3), 64'd0);
            chk("stall/hold_valid", 64'(out_valid3), 64'd1);
            chk("stall/hold_data", 64'(out_data3), 64'h0011);
            @(posedge clk); #1;
        end
        out_ready3 = 1'b1;
        #1 chk("stall/in_ready_release", 64'(in_ready3), 64'd1);
        model_beat(0, 1'b1, 5'b0);
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        check_out(0, "stall_b");
        chk("stall/second", 64'(out_data3), 64'h0022);

        // Reset while a result is held
        idle();
        set_lanes(16'h7, 16'h7, 16'h8, 0, 0);
        in_data3 = {lane[2], lane[1], lane[0]};
        in_valid3 = 1'b1; out_ready3 = 1'b0;
        model_beat(0, 1'b1, 5'b0);
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        check_out(0, "pre_rst");
        #2 rst_n = 1'b0;
        #1 check_reset("midrst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready3 = 1'b1;

        // Five lanes: retire lanes 0 and 1, then vote over three
        set_lanes(16'h1, 16'h2, 16'hA, 16'hA, 16'hA);
        for (int b = 0; b < 4; b++) beat(1, 5'b0);
        chk("five/failed", 64'(failed5), 64'b00011);
        set_lanes(16'hB, 16'hB, 16'hA, 16'hA, 16'hB);
        beat(1, 5'b0);
        chk("five/data", 64'(out_data5), 64'hA);
        chk("five/mask", 64'(mask5), 64'b10000);
        chk("five/degraded", 64'(degr5), 64'd0);

        // Lane 4 alternates so it never retires but its counter saturates
        for (int rep = 0; rep < 3; rep++) begin
            set_lanes(16'hB, 16'hB, 16'hA, 16'hA, 16'hA);
            beat(1, 5'b0);
            set_lanes(16'hB, 16'hB, 16'hA, 16'hA, 16'hB);
            for (int b = 0; b < 3; b++) beat(1, 5'b0);
        end
        chk("sat/err4", 64'(errcnt5[14:12]), 64'd7);
        chk("sat/failed4", 64'(failed5[4]), 64'd0);

        // Randomized traffic on both instances
        for (int it = 0; it < 300; it++) begin
            k    = int'($urandom_range(0, 1));
            base = W'($urandom);
            alt  = base ^ (W'(1) << $urandom_range(0, W - 1));
            for (int i = 0; i < 5; i++) begin
                r = int'($urandom_range(0, 9));
                lane[i] = (r < 6) ? base : (r < 8) ? alt : W'($urandom);
            end
            clr = ($urandom_range(0, 7) == 0) ? (5'b1 << $urandom_range(0, 4)) : 5'b0;
            if (k == 0) clr = clr & 5'b00111;
            if ($urandom_range(0, 5) == 0) idle();
            beat(k, clr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmr_voter_seq.md
Name: tmr_voter_seq

Overview:
- Registered, handshaked N-modular-redundancy voter for replicated ALU results (3 or 5 lanes).
- Sits between the replicated ALUs and writeback.
- Votes each accepted beat and tracks per-channel disagreement history.
- Retires a channel that disagrees persistently and keeps voting over the remaining healthy channels, in degraded mode when needed.

Parameters:
- WIDTH, 64: result width in bits.
- NUM_CH, 3: number of replicated channels; legal values are 3 and 5.
- FAULT_THRESH, 4: consecutive minority votes that retire a channel; range 1..15.
- CNT_W, 8: width of each per-channel saturating error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  voter can accept a beat.
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  voted result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  voted result.
- out_no_majority  out  1  no majority existed for this beat.
- out_minority_mask  out  NUM_CH  healthy channels that disagreed with out_data.
- out_degraded  out  1  fewer than 3 healthy channels when the beat was voted.
- clr_fault  in  NUM_CH  one-cycle pulse; returns channel i to HEALTHY and zeroes its counter.
- ch_failed  out  NUM_CH  channel is in FAILED state.
- ch_err_cnt  out  NUM_CH*CNT_W  saturating minority-vote count per channel.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_no_majority=0, out_minority_mask=0, out_degraded=0.
  - All channels HEALTHY, ch_failed=0, ch_err_cnt=0, consecutive counters=0.
  - Reset mid-beat drops the held beat; no output is produced for it.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Beat accepted when in_valid && in_ready; result registered with 1-cycle latency.
  - out_data and the status outputs are held stable while out_valid && !out_ready.
  - Back-to-back accepts give full throughput.
- Healthy set H = channels not FAILED, sampled at accept; h = |H|.
- Word vote (default):
  - For each channel i in H, agree_i = number of channels in H whose word equals word i, including itself.
  - Winner = lowest-index i with agree_i > h/2 (integer division).
  - h=2: majority only if both words are equal.
  - h=1: that channel passes through; majority is true, out_degraded=1.
  - h=0: out_data=0, out_no_majority=1; nothing is counted.
  - No winner: out_data = word of lowest-index healthy channel, out_no_majority=1, out_minority_mask=0.
  - out_degraded=1 whenever h<3.
- Channel FSM, evaluated per accepted beat only when a majority exists:
  - HEALTHY: minority vote -> SUSPECT with consec=1.
  - SUSPECT, minority vote: consec+1; when consec reaches FAULT_THRESH -> FAILED.
  - SUSPECT, agreeing vote: -> HEALTHY with consec=0.
  - FAILED is sticky; the channel is excluded from H starting with the next accepted beat.
  - ch_err_cnt increments on every minority vote and saturates at all-ones.
  - FAILED channels do not count.
  - Beats with no majority change no FSM or counter.
- clr_fault[i] takes priority over an update in the same cycle: channel i -> HEALTHY, consec=0, ch_err_cnt=0.
- ch_failed and ch_err_cnt update in the same cycle that out_valid rises for the beat that caused the change.

Optional Feature:
- Macro: TMR_VOTER_BITWISE_EN.
- Defined:
  - Per-bit majority over H; each bit takes the value held by more than h/2 healthy channels.
  - A tie (h even) takes the bit from the lowest-index healthy channel.
  - out_no_majority=1 only when h=0 or when any bit tied.
  - Minority = healthy channel whose word differs from out_data.
- Undefined: word vote as above; no bitwise logic is instantiated.

Test Plan:
- NUM_CH=3, all lanes 0x1234, out_ready=1 -> next cycle out_valid=1, out_data=0x1234, mask=0, no_majority=0, counters 0.
- NUM_CH=3, lane2=0xDEAD, lanes 0/1=0x5 for 4 beats (FAULT_THRESH=4):
  - Every beat: out_data=0x5, mask=3'b100.
  - After the 4th beat: ch_failed=3'b100, ch_err_cnt[2]=4.
  - 5th beat: out_degraded=1.
- Lanes 0x1/0x2/0x3 -> out_no_majority=1, out_data=0x1, all counters unchanged.
- out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable, no beats lost; second beat appears the cycle after out_ready=1.
- After the channel-2 failure, pulse clr_fault=3'b100 in the same cycle as a minority beat on lane 2 -> ch_failed=0, ch_err_cnt[2]=0.
- Assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 immediately; all counters 0.
- NUM_CH=5 with lanes 0,1 failed and lanes 2,3,4 = 0xA/0xA/0xB -> out_data=0xA, mask=5'b10000, out_degraded=0.
